// File: rtl/mdu_hilo_if.sv
// Handshake and result bundle between the execute stage and the HI/LO
// multiply/divide unit.
interface mdu_hilo_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// One iteration per clock on operand magnitudes, then sign fix-up.
module mdu_hilo #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       reset,
    mdu_hilo_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic               is_div_q, is_div_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic               dz_q, dz_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               sgn_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [WIDTH:0]     div_up;
    logic [WIDTH:0]     div_dif;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_nxt;

    logic               diff_sgn;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;

    assign sgn_op = ~bus.op[0];
    assign a_neg  = sgn_op & bus.a[WIDTH-1];
    assign b_neg  = sgn_op & bus.b[WIDTH-1];
    assign mag_a  = a_neg ? -bus.a : bus.a;
    assign mag_b  = b_neg ? -bus.b : bus.b;

    // Multiply: acc = {partial, multiplier}, add then shift right.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, dsr_q} : '0);
    assign mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {remainder, quotient}, shift left then trial subtract.
    assign div_up  = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_ge  = div_up >= {1'b0, dsr_q};
    assign div_dif = div_up - {1'b0, dsr_q};
    assign div_nxt = {div_ge ? div_dif[WIDTH-1:0] : div_up[WIDTH-1:0],
                      acc_q[WIDTH-2:0], div_ge};

    // A zero divisor yields all-ones quotient and rem=|a|, so hi=a after fix.
    assign diff_sgn = neg_a_q ^ neg_b_q;
    assign prod_s   = diff_sgn ? -acc_q : acc_q;
    assign quo_s    = dz_q ? '1
                    : diff_sgn ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_s    = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH]
                              : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        dsr_d    = dsr_q;
        is_div_d = is_div_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        dz_d     = dz_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    is_div_d = bus.op[1];
                    neg_a_d  = a_neg;
                    neg_b_d  = b_neg;
                    dz_d     = bus.op[1] & (bus.b == '0);
                    acc_d    = bus.op[1] ? {{WIDTH{1'b0}}, mag_a}
                                         : {{WIDTH{1'b0}}, mag_b};
                    dsr_d    = bus.op[1] ? mag_b : mag_a;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = CALC;
                end else begin
                    if (bus.mthi) hi_d = bus.wdata;
                    if (bus.mtlo) lo_d = bus.wdata;
                end
            end
            CALC: begin
                acc_d = is_div_q ? div_nxt : mul_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    hi_d = rem_s;
                    lo_d = quo_s;
                end else begin
                    hi_d = prod_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_s[WIDTH-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            dsr_q    <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            dsr_q    <= dsr_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            dz_q     <= dz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: latency, results, moves, ignores, reset abort.
module tb_mdu_hilo;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    int   lat;
    int   nbusy;
    int   ndone;

    mdu_hilo_if #(.WIDTH(32)) bus ();

    mdu_hilo #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch, scramble operands, optionally poke start+mtlo mid-op,
    // then wait (bounded) for done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int poke);
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.a     = 32'h5A5A_1234;
        bus.b     = 32'hC3C3_0000;
        lat   = 0;
        nbusy = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) nbusy++;
            if (poke > 0 && lat == poke) begin
                bus.start = 1'b1;
                bus.op    = 2'b11;
                bus.mtlo  = 1'b1;
                bus.wdata = 32'h0000_AAAA;
            end
            step();
            lat++;
            bus.start = 1'b0;
            bus.mtlo  = 1'b0;
        end
    endtask

    initial begin
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.wdata = '0;
        repeat (3) step();
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        reset = 1'b1;
        step();

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        chk("multu_lat", lat, 33);
        chk("multu_busy_cyc", nbusy, 33);
        chk("multu_busy_end", bus.busy, 0);
        chk("multu_hi", bus.hi, 64'hFFFF_FFFE);
        chk("multu_lo", bus.lo, 64'h0000_0001);
        step();
        chk("multu_done_once", bus.done, 0);

        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 0);
        chk("mult_lat", lat, 33);
        chk("mult_hi", bus.hi, 64'hFFFF_FFFF);
        chk("mult_lo", bus.lo, 64'hFFFF_FFEB);
        step();
        bus.mthi  = 1'b1;
        bus.wdata = 32'h1234_5678;
        step();
        bus.mthi  = 1'b0;
        chk("mthi_hi", bus.hi, 64'h1234_5678);
        chk("mthi_lo", bus.lo, 64'hFFFF_FFEB);
        chk("mthi_done", bus.done, 0);
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h0BAD_F00D;
        step();
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        chk("mtboth_hi", bus.hi, 64'h0BAD_F00D);
        chk("mtboth_lo", bus.lo, 64'h0BAD_F00D);

        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0);
        chk("div_lo", bus.lo, 64'hFFFF_FFFD);
        chk("div_hi", bus.hi, 64'hFFFF_FFFF);
        step();
        run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 0);
        chk("divu_lo", bus.lo, 64'h7FFF_FFFC);
        chk("divu_hi", bus.hi, 64'h0000_0001);
        step();
        run_op(2'b11, 32'h0000_0064, 32'h0000_0000, 0);
        chk("divu0_lat", lat, 33);
        chk("divu0_lo", bus.lo, 64'hFFFF_FFFF);
        chk("divu0_hi", bus.hi, 64'h0000_0064);
        step();
        run_op(2'b10, 32'hFFFF_FF9C, 32'h0000_0000, 0);
        chk("div0_lo", bus.lo, 64'hFFFF_FFFF);
        chk("div0_hi", bus.hi, 64'hFFFF_FF9C);
        step();
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("divovf_lo", bus.lo, 64'h8000_0000);
        chk("divovf_hi", bus.hi, 64'h0);
        step();

        run_op(2'b01, 32'h0000_0005, 32'h0000_0006, 10);
        chk("ign_lat", lat, 33);
        chk("ign_hi", bus.hi, 64'h0);
        chk("ign_lo", bus.lo, 64'd30);
        run_op(2'b11, 32'd100, 32'd7, 0);
        chk("b2b_lat", lat, 33);
        chk("b2b_lo", bus.lo, 64'd14);
        chk("b2b_hi", bus.hi, 64'd2);
        step();

        bus.op    = 2'b10;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (19) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("abort_hi", bus.hi, 0);
        chk("abort_lo", bus.lo, 0);
        chk("abort_busy", bus.busy, 0);
        ndone = 0;
        repeat (20) begin
            if (bus.done) ndone++;
            step();
        end
        chk("abort_no_done", ndone, 0);
        chk("abort_hold_lo", bus.lo, 0);
        run_op(2'b11, 32'd100, 32'd7, 0);
        chk("fresh_lat", lat, 33);
        chk("fresh_lo", bus.lo, 64'd14);
        chk("fresh_hi", bus.hi, 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Iterative multiply/divide unit with its own HI/LO result registers. Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits beside the ALU in the execute stage: operands come from busA/busB, and hi/lo feed the writeback mux for MFHI/MFLO.
- Takes 33 clocks per operation. busy drives the core's stall logic.

Parameters:
- WIDTH, 32, operand and HI/LO width. The iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- start  input  1  launch an operation; sampled only in IDLE.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  WIDTH  operand A from busA (multiplicand / dividend).
- b  input  WIDTH  operand B from busB (multiplier / divisor).
- mthi  input  1  write wdata to HI.
- mtlo  input  1  write wdata to LO.
- wdata  input  WIDTH  data for MTHI/MTLO.
- busy  output  1  operation in progress; the core stalls on MFHI/MFLO/MULT/DIV while this is 1.
- done  output  1  one-cycle pulse when HI/LO take a new result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset==0 at a clock edge):
  - Forces state IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
  - Aborts any operation in flight; no partial result reaches hi/lo.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - On an edge with start=1: latch operand magnitudes and sign flags, clear the accumulator, counter=0, go to CALC.
  - Signed ops (MULT, DIV) take the two's-complement magnitude of negative operands. Unsigned ops use the raw operands.
- CALC: one iteration per edge, counter increments. After WIDTH iterations, go to FIX.
  - Multiply: radix-2 shift-add on the magnitudes, 2*WIDTH-bit product.
  - Divide: restoring shift-subtract, WIDTH-bit quotient and WIDTH-bit remainder.
- FIX (single edge): apply sign correction, write hi/lo, assert done, return to IDLE.
  - MULT: negate the 64-bit product if the operand signs differ. hi=product[63:32], lo=product[31:0].
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign. lo=quotient, hi=remainder.
  - MULTU/DIVU: no correction.
- Timing, with start sampled at edge k:
  - busy=1 from after edge k through edge k+33, i.e. 33 cycles.
  - hi/lo update at edge k+33.
  - done=1 for exactly the cycle following edge k+33.
  - busy=0 in that same cycle, so a back-to-back start can be sampled at edge k+34.
- Divide by zero (b==0, DIV or DIVU): lo=all ones, hi=a (original signed/unsigned value). Same 33-cycle latency; no exception.
- Signed overflow (DIV, a=0x80000000, b=0xFFFFFFFF): lo=0x80000000, hi=0.
- start while busy: ignored.
- Operand changes on a/b after the start edge: no effect.
- mthi/mtlo:
  - Honoured only in IDLE with start=0. Takes effect at the next edge; done stays 0.
  - Both asserted together: HI and LO both receive wdata.
  - Ignored while busy.
  - start=1 together with mthi/mtlo in IDLE: start wins, the move is dropped.
- Outputs are registered only; no combinational path from inputs to busy, done, hi or lo.

Test Plan:
- Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy 33 cycles, done pulses once, hi=0xFFFFFFFE lo=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=0x00000007 -> hi=0xFFFFFFFF lo=0xFFFFFFEB (-21); then MTHI wdata=0x12345678 in IDLE -> hi=0x12345678 next cycle, lo unchanged.
- DIV a=0xFFFFFFF9 (-7) b=0x00000002 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU same operands -> lo=0x7FFFFFFC, hi=0x00000001.
- DIVU a=0x00000064 b=0 -> lo=0xFFFFFFFF hi=0x00000064. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
- Start MULTU 5*6; at cycle 10 pulse start (DIVU) and mtlo with wdata=0xAAAA -> both ignored, final hi=0 lo=30. Pulse start at edge k+34 -> new op accepted, no idle gap.
- Start DIV 100/7, drop reset low at cycle 20 for one edge -> hi=lo=0, busy=0, no done pulse; a fresh DIVU 100/7 then gives lo=14 hi=2.
